rr_arbitrated_fifos: RTL

- Bank of NUM_FIFOS independent circular FIFOs with a real round-robin arbiter draining them onto one shared valid/ready output. Each word leaves with its source tag.
- Replaces the abstract, externally driven grant of the previous generation.
- Sits between per-source producers and a single consumer, e.g. a scoreboard-checked shared sink.

---
 rtl/rr_arb_pkg.sv | 36 +++
 rtl/rr_arbitrated_fifos_if.sv | 31 +++
 rtl/rr_chan_fifo.sv | 70 +++++++
 rtl/rr_arbitrated_fifos.sv | 98 +++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared widths, reset constants and round-robin pick for rr_arbitrated_fifos
package rr_arb_pkg;

  localparam int MAX_CH = 32;

  localparam int   RST_PTR = 0;
  localparam logic RST_VLD = 1'b0;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First requester at or after ptr, scanning upward and wrapping at n.
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input int ptr, input int n);
    logic [MAX_CH-1:0] g;
    logic [MAX_CH-1:0] sh;
    logic              found;
    int                idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        sh = req >> idx;
        if (!found && sh[0]) begin
          g     = g | (MAX_CH'(1) << idx);
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbitrated_fifos_if.sv
// rtl/rr_arbitrated_fifos_if.sv - producer/consumer bundle for rr_arbitrated_fifos
interface rr_arbitrated_fifos_if
  import rr_arb_pkg::*;
#(
  parameter int NUM_FIFOS = 4,
  parameter int WIDTH     = 8
);
  localparam int TAGWIDTH = clog2_min1(NUM_FIFOS);

  logic [NUM_FIFOS-1:0]       push;
  logic [NUM_FIFOS*WIDTH-1:0] flat_data_in;
  logic [NUM_FIFOS-1:0]       full;
  logic [NUM_FIFOS-1:0]       empty;
  logic [NUM_FIFOS-1:0]       overflow;
  logic                       out_vld;
  logic                       out_rdy;
  logic [WIDTH-1:0]           data_out;
  logic [TAGWIDTH-1:0]        out_tag;
  logic [NUM_FIFOS-1:0]       gnt;

  modport master (
    output push, flat_data_in, out_rdy,
    input  full, empty, overflow, out_vld, data_out, out_tag, gnt
  );

  modport slave (
    input  push, flat_data_in, out_rdy,
    output full, empty, overflow, out_vld, data_out, out_tag, gnt
  );

endinterface

// File: rtl/rr_chan_fifo.sv
// rtl/rr_chan_fifo.sv - single-channel circular FIFO with count, full/empty and sticky overflow
module rr_chan_fifo
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);
  localparam int CW = clog2_min1(DEPTH + 1);
  localparam int PW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             wr_en, rd_en;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign overflow_o = ovf_q;
  assign head_o     = mem_q[rd_ptr_q];

  // Fullness is judged on the current state, so a pop never makes room for a same-cycle push.
  assign wr_en = push_i & ~full_o;
  assign rd_en = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_en ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_en ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    ovf_d    = ovf_q | (push_i & full_o);
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rr_arbitrated_fifos.sv
// rtl/rr_arbitrated_fifos.sv - FIFO bank drained by a round-robin arbiter onto one valid/ready port
// Optional output skid register: RR_OUT_REG_EN.
module rr_arbitrated_fifos
  import rr_arb_pkg::*;
#(
  parameter int NUM_FIFOS = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_arbitrated_fifos_if.slave  bus
);
  localparam int TAGWIDTH = clog2_min1(NUM_FIFOS);

  logic [NUM_FIFOS-1:0] empty_w, full_w, ovf_w, pop_w, req_w, gnt_c;
  logic [WIDTH-1:0]     head_w [NUM_FIFOS];
  logic [TAGWIDTH-1:0]  rr_ptr_q, rr_ptr_d, tag_c;
  logic [WIDTH-1:0]     data_c;
  logic                 vld_c, adv_w;

  for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_ch
    rr_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (bus.push[gi]),
      .data_i     (bus.flat_data_in[gi*WIDTH +: WIDTH]),
      .pop_i      (pop_w[gi]),
      .head_o     (head_w[gi]),
      .full_o     (full_w[gi]),
      .empty_o    (empty_w[gi]),
      .overflow_o (ovf_w[gi])
    );
  end

  assign req_w = ~empty_w;

  always_comb begin
    gnt_c  = NUM_FIFOS'(rr_pick(MAX_CH'(req_w), int'(rr_ptr_q), NUM_FIFOS));
    tag_c  = '0;
    data_c = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (gnt_c[i]) begin
        tag_c  = TAGWIDTH'(i);
        data_c = head_w[i];
      end
    end
    vld_c    = |gnt_c;
    rr_ptr_d = (int'(tag_c) == NUM_FIFOS - 1) ? '0 : tag_c + 1'b1;
  end

`ifdef RR_OUT_REG_EN
  logic                vld_q;
  logic [WIDTH-1:0]    data_q;
  logic [TAGWIDTH-1:0] tag_q;

  // Refill the slot whenever it is free or being drained, so back-to-back words flow at full rate.
  assign adv_w = vld_c & (~vld_q | bus.out_rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= RST_VLD;
      data_q <= '0;
      tag_q  <= '0;
    end else if (adv_w) begin
      vld_q  <= 1'b1;
      data_q <= data_c;
      tag_q  <= tag_c;
    end else if (bus.out_rdy) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
    end
  end

  assign bus.out_vld  = vld_q;
  assign bus.data_out = data_q;
  assign bus.out_tag  = tag_q;
`else
  assign adv_w        = vld_c & bus.out_rdy;
  assign bus.out_vld  = vld_c;
  assign bus.data_out = data_c;
  assign bus.out_tag  = tag_c;
`endif

  assign pop_w = gnt_c & {NUM_FIFOS{adv_w}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rr_ptr_q <= TAGWIDTH'(RST_PTR);
    else if (adv_w) rr_ptr_q <= rr_ptr_d;
  end

  assign bus.gnt      = gnt_c;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.overflow = ovf_w;

endmodule
